noc_out_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one NoC output link among N input circular queues (64-bit flits).
- Pops flits from the granted queue and drives them through a one-stage output register into the downstream queue's write port.
- Holds the grant from head flit to tail flit, so packets are never interleaved.
- Sits between the input queues of a router and the next queue or link.

---
 rtl/noc_out_arbiter.sv | 144 ++++++++++++++
 tb/tb_noc_out_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter
//   Round-robin, packet-locked arbiter sharing one NoC output link among N
//   input queues. The grant is held from head flit to tail flit so packets
//   are never interleaved. Flits pass through a single output register that
//   feeds the write port of the downstream queue.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   in_empty  [N]    empty flag of each input queue
//   in_flit   [N*W]  head-of-queue flit of each queue, queue i at [i*W +: W]
//   in_rd     [N]    pop strobe to the granted queue (at most one bit high)
//   out_flit  [W]    registered flit to downstream
//   out_wr           registered write strobe, accepted when out_full=0
//   out_full         downstream queue full
//   grant     [N]    one-hot current owner, 0 while idle
//   busy             high while a packet owns the link
//   err              sticky framing error
module noc_out_arbiter #(
    parameter int N = 4,
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_empty,
    input  logic [N*W-1:0] in_flit,
    output logic [N-1:0]   in_rd,
    output logic [W-1:0]   out_flit,
    output logic           out_wr,
    input  logic           out_full,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic           first;

    logic [PW-1:0]  owner;
    logic [W-1:0]   owner_flit;
    logic           owner_ne;
    logic           mv;
    logic           pop;
    logic [1:0]     ftype;
    logic           pkt_end;
    logic           frame_bad;
    logic           found;
    logic [PW-1:0]  pick;
    logic [PW-1:0]  idx;

    // Owner index and its head flit, decoded from the one-hot grant.
    always_comb begin
        owner      = '0;
        owner_flit = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                owner      = PW'(i);
                owner_flit = in_flit[i*W +: W];
            end
        end
    end

    assign owner_ne = |(grant & ~in_empty);

    // The output register can take a new flit when it is empty or draining.
    assign mv  = ~out_wr | ~out_full;
    assign pop = (state == LOCKED) & owner_ne & mv & ~reset;

    assign in_rd = pop ? grant : '0;

    // Type bit 0 marks tail/single (packet end); bit 1 marks head/single.
    // A first flit must carry a head bit, any later flit must not.
    assign ftype     = owner_flit[W-1:W-2];
    assign pkt_end   = ftype[0];
    assign frame_bad = first ? ~ftype[1] : ftype[1];

    // Rotating search starting just after the last owner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && !in_empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= PW'(N - 1);
            first    <= 1'b0;
            err      <= 1'b0;
            out_wr   <= 1'b0;
            out_flit <= '0;
        end else begin
            // Output register: load on pop, drop the strobe once accepted.
            if (pop) begin
                out_flit <= owner_flit;
                out_wr   <= 1'b1;
            end else if (mv) begin
                out_wr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        state <= LOCKED;
                        grant <= {{(N-1){1'b0}}, 1'b1} << pick;
                        first <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (pop) begin
                        first <= 1'b0;
                        if (frame_bad) begin
                            err <= 1'b1;
                        end
                        if (pkt_end) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= owner;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Testbench for noc_out_arbiter: input queues are modelled as SV queues,
// expected output flits go to a scoreboard queue and are compared when the
// downstream side accepts a write.
module tb_noc_out_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_empty;
    logic [N*W-1:0] in_flit;
    logic [N-1:0]   in_rd;
    logic [W-1:0]   out_flit;
    logic           out_wr;
    logic           out_full = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err;

    logic [W-1:0] qd [N][$];
    logic [W-1:0] sb [$];
    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    noc_out_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_empty (in_empty),
        .in_flit  (in_flit),
        .in_rd    (in_rd),
        .out_flit (out_flit),
        .out_wr   (out_wr),
        .out_full (out_full),
        .grant    (grant),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (qd[i].size() == 0);
            in_flit[i*W +: W] = (qd[i].size() != 0) ? qd[i][0] : '0;
        end
    endtask

    task automatic push(input int q, input logic [W-1:0] f, input bit expect_out);
        qd[q].push_back(f);
        if (expect_out) sb.push_back(f);
        refresh();
    endtask

    // One clock: accepted-write scoreboard compare and pop capture at the
    // falling edge, queue pops just after the rising edge. Returns at +2.
    task automatic cycle();
        logic [N-1:0] pend;
        logic [W-1:0] e;
        @(negedge clk);
        if (!reset && out_wr === 1'b1 && !out_full) begin
            accepted++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL out_accept unexpected flit actual=%h required=none", out_flit);
            end else begin
                e = sb.pop_front();
                if (out_flit !== e) begin
                    failures++;
                    $display("FAIL out_accept flit actual=%h required=%h", out_flit, e);
                end
            end
        end
        checks++;
        if (!$onehot0(in_rd)) begin
            failures++;
            $display("FAIL in_rd_onehot actual=%b required=at most one bit", in_rd);
        end
        pend = in_rd;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                checks++;
                if (qd[i].size() == 0) begin
                    failures++;
                    $display("FAIL pop_empty queue=%0d actual=pop required=no pop", i);
                end else begin
                    void'(qd[i].pop_front());
                end
            end
        end
        refresh();
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) qd[i].delete();
        sb.delete();
        refresh();
        out_full = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_wr === 1'b1 || in_empty != '1) && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || in_empty != '1) begin
            failures++;
            $display("FAIL %s_drain pending_flits actual=%0d required=0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        refresh();
        reset = 1'b1;
        cycle();
        cycle();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant actual=%b required=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err actual=%b required=0", err); end
        checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL rst_out_wr actual=%b required=0", out_wr); end
        checks++; if (out_flit !== 64'h0) begin failures++; $display("FAIL rst_out_flit actual=%h required=0", out_flit); end
        checks++; if (in_rd !== 4'b0000) begin failures++; $display("FAIL rst_in_rd actual=%b required=0000", in_rd); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_single_packet();
        logic [N-1:0] eg [5] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        logic [N-1:0] er [5] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        logic         ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ef [5] = '{64'h0, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0002,
                                 64'h4000_0000_0000_0003, 64'h0};
        do_reset();
        push(0, 64'h8000_0000_0000_0001, 1'b1);
        push(0, 64'h0000_0000_0000_0002, 1'b1);
        push(0, 64'h4000_0000_0000_0003, 1'b1);
        #1;
        checks++; if (in_rd !== 4'b0000) begin failures++; $display("FAIL sp_idle_in_rd actual=%b required=0000", in_rd); end
        for (int c = 0; c < 5; c++) begin
            cycle();
            #1;
            checks++; if (grant !== eg[c]) begin failures++; $display("FAIL sp_grant c%0d actual=%b required=%b", c+1, grant, eg[c]); end
            checks++; if (in_rd !== er[c]) begin failures++; $display("FAIL sp_in_rd c%0d actual=%b required=%b", c+1, in_rd, er[c]); end
            checks++; if (out_wr !== ew[c]) begin failures++; $display("FAIL sp_out_wr c%0d actual=%b required=%b", c+1, out_wr, ew[c]); end
            if (ew[c]) begin
                checks++; if (out_flit !== ef[c]) begin failures++; $display("FAIL sp_out_flit c%0d actual=%h required=%h", c+1, out_flit, ef[c]); end
            end
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL sp_err actual=%b required=0", err); end
        drain("sp");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg [11] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h4};
        do_reset();
        for (int i = 0; i < N; i++) push(i, 64'hC000_0000_0000_0000 | 64'(i), 1'b1);
        for (int c = 0; c < 11; c++) begin
            cycle();
            if (c == 7) begin
                push(0, 64'hC000_0000_0000_0010, 1'b1);
                push(2, 64'hC000_0000_0000_0012, 1'b1);
            end
            #1;
            checks++; if (grant !== eg[c]) begin failures++; $display("FAIL rr_grant c%0d actual=%b required=%b", c+1, grant, eg[c]); end
            checks++; if (in_rd !== eg[c]) begin failures++; $display("FAIL rr_in_rd c%0d actual=%b required=%b", c+1, in_rd, eg[c]); end
        end
        drain("rr");
    endtask

    task automatic test_backpressure();
        logic         fl [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [N-1:0] eg [9] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        logic [N-1:0] er [9] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
        logic         ew [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ef [9] = '{64'h0, 64'h8000_0000_0000_0011, 64'h12, 64'h12, 64'h12,
                                 64'h12, 64'h13, 64'h4000_0000_0000_0014, 64'h0};
        int a0;
        do_reset();
        a0 = accepted;
        push(1, 64'h8000_0000_0000_0011, 1'b1);
        push(1, 64'h0000_0000_0000_0012, 1'b1);
        push(1, 64'h0000_0000_0000_0013, 1'b1);
        push(1, 64'h4000_0000_0000_0014, 1'b1);
        for (int c = 0; c < 9; c++) begin
            cycle();
            out_full = fl[c];
            #1;
            checks++; if (grant !== eg[c]) begin failures++; $display("FAIL bp_grant c%0d actual=%b required=%b", c+1, grant, eg[c]); end
            checks++; if (in_rd !== er[c]) begin failures++; $display("FAIL bp_in_rd c%0d actual=%b required=%b", c+1, in_rd, er[c]); end
            checks++; if (out_wr !== ew[c]) begin failures++; $display("FAIL bp_out_wr c%0d actual=%b required=%b", c+1, out_wr, ew[c]); end
            if (ew[c]) begin
                checks++; if (out_flit !== ef[c]) begin failures++; $display("FAIL bp_out_flit c%0d actual=%h required=%h", c+1, out_flit, ef[c]); end
            end
        end
        drain("bp");
        checks++; if (accepted - a0 !== 4) begin failures++; $display("FAIL bp_write_count actual=%0d required=4", accepted - a0); end
    endtask

    task automatic test_no_interleave();
        logic [N-1:0] eg [6] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8};
        do_reset();
        push(2, 64'h8000_0000_0000_0021, 1'b1);
        push(2, 64'h0000_0000_0000_0022, 1'b1);
        push(2, 64'h0000_0000_0000_0023, 1'b1);
        push(2, 64'h4000_0000_0000_0024, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c == 1) push(3, 64'hC000_0000_0000_0031, 1'b1);
            #1;
            checks++; if (grant !== eg[c]) begin failures++; $display("FAIL ni_grant c%0d actual=%b required=%b", c+1, grant, eg[c]); end
            checks++; if (in_rd !== eg[c]) begin failures++; $display("FAIL ni_in_rd c%0d actual=%b required=%b", c+1, in_rd, eg[c]); end
        end
        drain("ni");
    endtask

    task automatic test_framing_error();
        do_reset();
        push(0, 64'h0000_0000_0000_0005, 1'b1);
        push(0, 64'h4000_0000_0000_0006, 1'b1);
        cycle();
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL fe_err_c1 actual=%b required=0", err); end
        cycle();
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fe_err_c2 actual=%b required=1", err); end
        checks++; if (out_flit !== 64'h5 || out_wr !== 1'b1) begin failures++; $display("FAIL fe_out_flit actual=%h/%b required=%h/1", out_flit, out_wr, 64'h5); end
        drain("fe");
        cycle();
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fe_err_sticky actual=%b required=1", err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push(1, 64'hC000_0000_0000_0041, 1'b1);
        drain("rm_pre");
        push(0, 64'h8000_0000_0000_0051, 1'b1);
        push(0, 64'h0000_0000_0000_0052, 1'b0);
        push(0, 64'h0000_0000_0000_0053, 1'b1);
        push(0, 64'h4000_0000_0000_0054, 1'b1);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        push(2, 64'hC000_0000_0000_0061, 1'b1);
        #1;
        checks++; if (in_rd !== 4'b0000) begin failures++; $display("FAIL rm_in_rd_in_reset actual=%b required=0000", in_rd); end
        cycle();
        reset = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rm_grant actual=%b required=0000", grant); end
        checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL rm_out_wr actual=%b required=0", out_wr); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_err actual=%b required=0", err); end
        checks++; if (in_rd !== 4'b0000) begin failures++; $display("FAIL rm_in_rd actual=%b required=0000", in_rd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy actual=%b required=0", busy); end
        cycle();
        #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rm_rearb_grant actual=%b required=0001", grant); end
        drain("rm");
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_no_interleave();
        test_framing_error();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
